// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer : pitch-by-pitch baseball game sequencer driving a base tracker
// Optional walk-off ending: GAME_SEQUENCER_WALKOFF_EN.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module game_sequencer #(
  parameter int INNINGS = 9,
  parameter int SCORE_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ev_valid,
  input  logic [2:0]         ev_code,
  output logic               ev_ready,
  input  logic [2:0]         base,
  output logic [3:0]         hit,
  output logic [1:0]         balls,
  output logic [1:0]         strikes,
  output logic [1:0]         outs,
  output logic [3:0]         inning,
  output logic               half,
  output logic [SCORE_W-1:0] score_away,
  output logic [SCORE_W-1:0] score_home,
  output logic               game_over
);

`ifdef GAME_SEQUENCER_WALKOFF_EN
  localparam bit WALKOFF = 1'b1;
`else
  localparam bit WALKOFF = 1'b0;
`endif

  localparam logic [2:0] EV_BALL   = 3'd0;
  localparam logic [2:0] EV_STRIKE = 3'd1;
  localparam logic [2:0] EV_FOUL   = 3'd2;
  localparam logic [2:0] EV_OUT    = 3'd3;
  localparam logic [3:0] REG_INN   = 4'(INNINGS);

  typedef enum logic [1:0] {PLAY, SETTLE, CHANGE, OVER} state_t;
  state_t state;

  logic [2:0]         runs;
  logic [SCORE_W:0]   away_sum, home_sum;
  logic [SCORE_W-1:0] away_sat, home_sat;
  logic               is_out;
  logic               late_inning;

  // base is {1st,2nd,3rd}; a walk credits runs exactly like a single
  always_comb begin
    runs = 3'd0;
    case (ev_code)
      EV_BALL, 3'd4: runs = {2'b00, base[0]};
      3'd5:          runs = {2'b00, base[1]} + {2'b00, base[0]};
      3'd6:          runs = {2'b00, base[2]} + {2'b00, base[1]} + {2'b00, base[0]};
      3'd7:          runs = {2'b00, base[2]} + {2'b00, base[1]} + {2'b00, base[0]} + 3'd1;
      default:       runs = 3'd0;
    endcase
  end

  assign away_sum    = {1'b0, score_away} + (SCORE_W+1)'(runs);
  assign home_sum    = {1'b0, score_home} + (SCORE_W+1)'(runs);
  assign away_sat    = away_sum[SCORE_W] ? '1 : away_sum[SCORE_W-1:0];
  assign home_sat    = home_sum[SCORE_W] ? '1 : home_sum[SCORE_W-1:0];
  assign is_out      = (ev_code == EV_OUT) || (ev_code == EV_STRIKE && strikes == 2'd2);
  assign late_inning = (inning >= REG_INN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= PLAY;
      ev_ready   <= 1'b1;
      hit        <= 4'b0000;
      balls      <= 2'd0;
      strikes    <= 2'd0;
      outs       <= 2'd0;
      inning     <= 4'd1;
      half       <= 1'b0;
      score_away <= '0;
      score_home <= '0;
      game_over  <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          if (ev_valid) begin
            if (is_out) begin
              balls   <= 2'd0;
              strikes <= 2'd0;
              if (outs == 2'd2) begin
                // third out: homer pulse sweeps the bases without crediting runs
                outs     <= 2'd3;
                hit      <= 4'b0001;
                state    <= CHANGE;
                ev_ready <= 1'b0;
              end else begin
                outs <= outs + 2'd1;
              end
            end else if (ev_code == EV_STRIKE) begin
              strikes <= strikes + 2'd1;
            end else if (ev_code == EV_FOUL) begin
              if (strikes < 2'd2) strikes <= strikes + 2'd1;
            end else if (ev_code == EV_BALL && balls != 2'd3) begin
              balls <= balls + 2'd1;
            end else begin
              // ball four or any hit: one-hot pulse, 1000 = single ... 0001 = homer
              hit      <= (ev_code == EV_BALL) ? 4'b1000 : (4'b1000 >> ev_code[1:0]);
              balls    <= 2'd0;
              strikes  <= 2'd0;
              state    <= SETTLE;
              ev_ready <= 1'b0;
              if (half) score_home <= home_sat;
              else      score_away <= away_sat;
            end
          end
        end
        SETTLE: begin
          hit <= 4'b0000;
          if (WALKOFF && half && late_inning && score_home > score_away) begin
            game_over <= 1'b1;
            state     <= OVER;
            ev_ready  <= 1'b0;
          end else begin
            state    <= PLAY;
            ev_ready <= 1'b1;
          end
        end
        CHANGE: begin
          hit  <= 4'b0000;
          outs <= 2'd0;
          if (!half) begin
            if (WALKOFF && late_inning && score_home > score_away) begin
              game_over <= 1'b1;
              state     <= OVER;
              ev_ready  <= 1'b0;
            end else begin
              half     <= 1'b1;
              state    <= PLAY;
              ev_ready <= 1'b1;
            end
          end else if ((late_inning && score_home != score_away) || inning == 4'd15) begin
            game_over <= 1'b1;
            state     <= OVER;
            ev_ready  <= 1'b0;
          end else begin
            half     <= 1'b0;
            inning   <= inning + 4'd1;
            state    <= PLAY;
            ev_ready <= 1'b1;
          end
        end
        default: begin
          ev_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_sequencer : directed self-checking bench with a base-runner tracker model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ev_valid = 1'b0;
  logic [2:0] ev_code = 3'd0;
  logic       ev_ready;
  logic [2:0] base;
  logic [3:0] hit;
  logic [1:0] balls, strikes, outs;
  logic [3:0] inning;
  logic       half;
  logic [4:0] score_away, score_home;
  logic       game_over;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [2:0] BALL = 3'd0, STRIKE = 3'd1, FOUL = 3'd2, OUT = 3'd3;
  localparam logic [2:0] HIT1 = 3'd4, HIT2 = 3'd5, HIT3 = 3'd6, HIT4 = 3'd7;

  always #5 clk = ~clk;

  game_sequencer #(.INNINGS(9), .SCORE_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_ready(ev_ready), .base(base), .hit(hit), .balls(balls),
    .strikes(strikes), .outs(outs), .inning(inning), .half(half),
    .score_away(score_away), .score_home(score_home), .game_over(game_over)
  );

  // uniform-advance tracker, base = {1st,2nd,3rd}
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) base <= 3'b000;
    else case (hit)
      4'b1000: base <= {1'b1, base[2], base[1]};
      4'b0100: base <= {1'b0, 1'b1, base[2]};
      4'b0010: base <= 3'b001;
      4'b0001: base <= 3'b000;
      default: base <= base;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    ev_valid = 1'b0;
    reset_n  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic send(input logic [2:0] code);
    int wait_cyc = 0;
    @(negedge clk);
    while (!ev_ready && wait_cyc < 8) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!ev_ready) chk("ready_timeout", ev_ready, 1);
    ev_valid = 1'b1;
    ev_code  = code;
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic three_outs();
    send(OUT);
    send(OUT);
    send(OUT);
    next_cycle();
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst_hit", hit, 0);
    chk("rst_balls", balls, 0);
    chk("rst_strikes", strikes, 0);
    chk("rst_outs", outs, 0);
    chk("rst_inning", inning, 1);
    chk("rst_half", half, 0);
    chk("rst_away", score_away, 0);
    chk("rst_home", score_home, 0);
    chk("rst_over", game_over, 0);
    chk("rst_ready", ev_ready, 1);

    // walk
    send(BALL); send(BALL); send(BALL);
    chk("three_balls", balls, 3);
    chk("three_balls_hit", hit, 0);
    send(BALL);
    chk("walk_hit", hit, 4'b1000);
    chk("walk_ready", ev_ready, 0);
    chk("walk_balls", balls, 0);
    chk("walk_runs", score_away, 0);
    next_cycle();
    chk("walk_hit_end", hit, 0);
    chk("walk_ready_back", ev_ready, 1);
    chk("walk_base", base, 3'b100);

    // load the bases, then a grand slam
    send(HIT1);
    chk("single_hit", hit, 4'b1000);
    send(HIT1);
    next_cycle();
    chk("loaded_base", base, 3'b111);
    chk("loaded_runs", score_away, 0);
    send(BALL);
    chk("ball_before_slam", balls, 1);
    send(HIT4);
    chk("slam_hit", hit, 4'b0001);
    chk("slam_score", score_away, 4);
    chk("slam_balls", balls, 0);
    next_cycle();
    chk("slam_base", base, 3'b000);
    chk("slam_hit_end", hit, 0);

    // strikes and fouls
    send(STRIKE); send(STRIKE);
    chk("two_strikes", strikes, 2);
    send(FOUL); send(FOUL); send(FOUL);
    chk("foul_hold", strikes, 2);
    chk("foul_outs", outs, 0);
    send(STRIKE);
    chk("k_outs", outs, 1);
    chk("k_strikes", strikes, 0);
    chk("k_ready", ev_ready, 1);

    // runners on 1st and 3rd, then inning-ending outs
    send(FOUL);
    chk("foul_from_zero", strikes, 1);
    send(HIT2);
    send(HIT1);
    next_cycle();
    chk("corners_base", base, 3'b101);
    chk("corners_score", score_away, 4);
    chk("corners_strikes", strikes, 0);
    send(OUT);
    chk("two_outs", outs, 2);
    send(OUT);
    chk("third_out", outs, 3);
    chk("third_out_hit", hit, 4'b0001);
    chk("third_out_ready", ev_ready, 0);
    chk("third_out_score", score_away, 4);
    next_cycle();
    chk("change_outs", outs, 0);
    chk("change_half", half, 1);
    chk("change_inning", inning, 1);
    chk("change_hit", hit, 0);
    chk("change_base", base, 3'b000);
    chk("change_ready", ev_ready, 1);
    chk("change_home", score_home, 0);

    // score saturation
    do_reset();
    for (int r = 0; r < 8; r++) begin
      send(HIT1); send(HIT1); send(HIT1); send(HIT4);
      if (r == 6) chk("score_28", score_away, 28);
    end
    chk("score_sat", score_away, 31);

    // scoreless regulation, extra inning, away wins in the 10th
    do_reset();
    for (int h = 0; h < 17; h++) three_outs();
    chk("bot9_inning", inning, 9);
    chk("bot9_half", half, 1);
    three_outs();
    chk("extra_inning", inning, 10);
    chk("extra_half", half, 0);
    chk("extra_over", game_over, 0);
    send(HIT4);
    chk("extra_away", score_away, 1);
    three_outs();
    chk("bot10_half", half, 1);
    chk("bot10_over", game_over, 0);
    three_outs();
    chk("final_over", game_over, 1);
    chk("final_ready", ev_ready, 0);
    chk("final_inning", inning, 10);
    @(negedge clk);
    ev_valid = 1'b1;
    ev_code  = BALL;
    next_cycle();
    next_cycle();
    ev_valid = 1'b0;
    chk("over_ignore_balls", balls, 0);
    chk("over_sticky", game_over, 1);
    chk("over_ready", ev_ready, 0);
    chk("over_hit", hit, 0);

    // tied 2-2 into the bottom of the 9th, single with runner on 3rd
    do_reset();
    send(HIT4); send(HIT4);
    three_outs();
    send(HIT4); send(HIT4);
    three_outs();
    chk("tied_away", score_away, 2);
    chk("tied_home", score_home, 2);
    for (int h = 0; h < 15; h++) three_outs();
    chk("wo_inning", inning, 9);
    chk("wo_half", half, 1);
    send(HIT3);
    send(HIT1);
    chk("wo_home", score_home, 3);
    chk("wo_away", score_away, 2);
    next_cycle();
`ifdef GAME_SEQUENCER_WALKOFF_EN
    chk("wo_over", game_over, 1);
    chk("wo_ready", ev_ready, 0);
`else
    chk("wo_over", game_over, 0);
    chk("wo_ready", ev_ready, 1);
    three_outs();
    chk("wo_late_over", game_over, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
